// File: rtl/keypad_4x4_scan.sv
// rtl/keypad_4x4_scan.sv - 4x4 matrix keypad column scanner with row debounce
//
// Drives one active-low column per slot and watches the four pulled-up rows.
// A single low row seen on a slot tick freezes the column and starts a
// debounce. After DEBOUNCE_TICKS matching samples the key code is reported
// once. Release is debounced the same way before scanning resumes.
//
// Ports:
//   clk        system clock
//   reset_p    asynchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low one-cold
//   key_value  last accepted key code {row_idx, col_idx}
//   key_valid  one-cycle pulse per accepted press
//   key_held   high from press acceptance until release acceptance

module keypad_4x4_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    latch_row;
  logic [3:0]    latch_col;
  logic          row_valid;
  logic          row_match;
  logic          row_idle;
  logic [3:0]    col_next;

  // Bit position of the single low bit in a one-cold pattern.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      default: low_idx = 2'd3;
    endcase
  endfunction

  // Rows are asynchronous to clk; only row_s is used past this point.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      row_m <= 4'b0000;
      row_s <= 4'b0000;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PW'(1);
    end
  end

  assign tick = (ps_cnt == PS_MAX);

  // Zero or several low rows (multi-key / ghosting) are treated as no key.
  always_comb begin
    row_valid = 1'b0;
    case (row_s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: row_valid = 1'b1;
      default:                            row_valid = 1'b0;
    endcase
  end

  assign row_match = (row_s == latch_row);
  assign row_idle  = (row_s == 4'b1111);
  assign cnt_inc   = cnt + CW'(1);
  assign col_next  = {col[2:0], col[3]};

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state     <= SCAN;
      col       <= 4'b1110;
      cnt       <= '0;
      latch_row <= 4'b0000;
      latch_col <= 4'b0000;
      key_value <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_valid) begin
              latch_row <= row_s;
              latch_col <= col;
              cnt       <= CW'(1);
              state     <= DEBOUNCE;
            end else begin
              col <= col_next;
            end
          end
          DEBOUNCE: begin
            if (row_match) begin
              if (cnt_inc == DB_MAX) begin
                key_value <= {low_idx(latch_row), low_idx(latch_col)};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= PRESSED;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= '0;
              col   <= col_next;
              state <= SCAN;
            end
          end
          PRESSED: begin
            // Column stays frozen, so keys in other columns are invisible.
            if (row_idle) begin
              cnt   <= CW'(1);
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (row_idle) begin
              if (cnt_inc == DB_MAX) begin
                key_held <= 1'b0;
                cnt      <= '0;
                col      <= col_next;
                state    <= SCAN;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Release bounce: back to held without a new key_valid.
              cnt   <= '0;
              state <= PRESSED;
            end
          end
          default: begin
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_4x4_scan.sv
// tb/tb_keypad_4x4_scan.sv - directed testbench for keypad_4x4_scan

module tb_keypad_4x4_scan;

  logic       clk;
  logic       reset_p;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_held;

  int checks;
  int passed;
  int pulses;
  int consec;
  logic prev_kv;

  logic       press_on;
  logic       press_all;
  logic [3:0] press_col;
  logic [3:0] press_row;

  keypad_4x4_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .row      (row),
    .col      (col),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  task automatic drive_row();
    if (press_all)
      row = 4'b1001;
    else if (press_on && col == press_col)
      row = press_row;
    else
      row = 4'b1111;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (key_valid === 1'b1) begin
      pulses++;
      if (prev_kv === 1'b1) consec++;
    end
    prev_kv = key_valid;
    drive_row();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    ok = (key_valid === 1'b1);
  endtask

  task automatic wait_held_low(output bit ok);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < 200) begin
      cyc();
      n++;
    end
    ok = (key_held === 1'b0);
  endtask

  // Returns at the first negedge after col rotates into 1110.
  task automatic wait_col_enter_1110(output bit ok);
    int n;
    n = 0;
    while (col === 4'b1110 && n < 100) begin
      cyc();
      n++;
    end
    while (col !== 4'b1110 && n < 100) begin
      cyc();
      n++;
    end
    ok = (col === 4'b1110);
  endtask

  task automatic test_reset();
    reset_p = 1'b0;
    #1 reset_p = 1'b1;
    #2;
    checks++; if (col !== 4'b1110) $display("FAIL reset_col: got %b expected %b", col, 4'b1110); else passed++;
    checks++; if (key_value !== 4'd0) $display("FAIL reset_key_value: got %b expected %b", key_value, 4'd0); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b expected 0", key_held); else passed++;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] seq [5];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int i = 0; i < 20; i++) begin
      checks++; if (col !== seq[i/4]) $display("FAIL idle_col[%0d]: got %b expected %b", i, col, seq[i/4]); else passed++;
      checks++; if (key_valid !== 1'b0) $display("FAIL idle_key_valid[%0d]: got %b expected 0", i, key_valid); else passed++;
      checks++; if (key_held !== 1'b0) $display("FAIL idle_key_held[%0d]: got %b expected 0", i, key_held); else passed++;
      cyc();
    end
  endtask

  task automatic test_press();
    bit ok;
    int p0;
    p0 = pulses;
    press_col = 4'b1101;
    press_row = 4'b1011;
    press_on  = 1'b1;
    drive_row();
    wait_valid(ok);
    checks++; if (!ok) $display("FAIL press_timeout: got key_valid %b expected 1", key_valid); else passed++;
    checks++; if (key_value !== 4'b1001) $display("FAIL press_key_value: got %b expected %b", key_value, 4'b1001); else passed++;
    checks++; if (key_held !== 1'b1) $display("FAIL press_key_held: got %b expected 1", key_held); else passed++;
    checks++; if (col !== 4'b1101) $display("FAIL press_col: got %b expected %b", col, 4'b1101); else passed++;
    cyc();
    checks++; if (key_valid !== 1'b0) $display("FAIL press_valid_width: got %b expected 0", key_valid); else passed++;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (col !== 4'b1101) $display("FAIL press_col_frozen[%0d]: got %b expected %b", i, col, 4'b1101); else passed++;
      checks++; if (key_held !== 1'b1) $display("FAIL press_held[%0d]: got %b expected 1", i, key_held); else passed++;
    end
    press_on = 1'b0;
    drive_row();
    wait_held_low(ok);
    checks++; if (!ok) $display("FAIL press_release_timeout: got key_held %b expected 0", key_held); else passed++;
    checks++; if (col !== 4'b1011) $display("FAIL press_release_col: got %b expected %b", col, 4'b1011); else passed++;
    checks++; if (pulses - p0 !== 1) $display("FAIL press_pulses: got %0d expected 1", pulses - p0); else passed++;
  endtask

  task automatic test_bounce();
    bit ok;
    int p0;
    p0 = pulses;
    wait_col_enter_1110(ok);
    checks++; if (!ok) $display("FAIL bounce_align_timeout: got col %b expected %b", col, 4'b1110); else passed++;
    press_col = 4'b1110;
    press_row = 4'b1110;
    press_on  = 1'b1;
    drive_row();
    repeat (4) cyc();
    checks++; if (col !== 4'b1110) $display("FAIL bounce_col_frozen: got %b expected %b", col, 4'b1110); else passed++;
    press_on = 1'b0;
    drive_row();
    repeat (4) cyc();
    checks++; if (col !== 4'b1101) $display("FAIL bounce_resume_col: got %b expected %b", col, 4'b1101); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL bounce_key_held: got %b expected 0", key_held); else passed++;
    checks++; if (pulses - p0 !== 0) $display("FAIL bounce_pulses: got %0d expected 0", pulses - p0); else passed++;
    checks++; if (key_value !== 4'b1001) $display("FAIL bounce_key_value: got %b expected %b", key_value, 4'b1001); else passed++;
  endtask

  task automatic test_release_glitch();
    bit ok;
    int p0;
    p0 = pulses;
    press_col = 4'b0111;
    press_row = 4'b0111;
    press_on  = 1'b1;
    drive_row();
    wait_valid(ok);
    checks++; if (!ok) $display("FAIL glitch_press_timeout: got key_valid %b expected 1", key_valid); else passed++;
    checks++; if (key_value !== 4'b1111) $display("FAIL glitch_key_value: got %b expected %b", key_value, 4'b1111); else passed++;
    press_on = 1'b0;
    drive_row();
    repeat (4) cyc();
    checks++; if (key_held !== 1'b1) $display("FAIL glitch_held_rel1: got %b expected 1", key_held); else passed++;
    press_on = 1'b1;
    drive_row();
    repeat (4) cyc();
    checks++; if (key_held !== 1'b1) $display("FAIL glitch_held_repress: got %b expected 1", key_held); else passed++;
    checks++; if (col !== 4'b0111) $display("FAIL glitch_col_frozen: got %b expected %b", col, 4'b0111); else passed++;
    press_on = 1'b0;
    drive_row();
    repeat (4) cyc();
    checks++; if (key_held !== 1'b1) $display("FAIL glitch_held_clean1: got %b expected 1", key_held); else passed++;
    repeat (4) cyc();
    checks++; if (key_held !== 1'b1) $display("FAIL glitch_held_clean2: got %b expected 1", key_held); else passed++;
    repeat (4) cyc();
    checks++; if (key_held !== 1'b0) $display("FAIL glitch_held_clean3: got %b expected 0", key_held); else passed++;
    checks++; if (col !== 4'b1110) $display("FAIL glitch_resume_col: got %b expected %b", col, 4'b1110); else passed++;
    checks++; if (pulses - p0 !== 1) $display("FAIL glitch_pulses: got %0d expected 1", pulses - p0); else passed++;
  endtask

  task automatic test_multi_key();
    int p0;
    int changes;
    logic [3:0] prev_col;
    p0 = pulses;
    changes = 0;
    press_all = 1'b1;
    drive_row();
    prev_col = col;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (col !== prev_col) changes++;
      prev_col = col;
    end
    checks++; if (changes !== 10) $display("FAIL multi_col_rotations: got %0d expected 10", changes); else passed++;
    checks++; if (pulses - p0 !== 0) $display("FAIL multi_pulses: got %0d expected 0", pulses - p0); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL multi_key_held: got %b expected 0", key_held); else passed++;
    checks++; if (key_value !== 4'b1111) $display("FAIL multi_key_value: got %b expected %b", key_value, 4'b1111); else passed++;
    press_all = 1'b0;
    drive_row();
  endtask

  task automatic test_reset_mid_debounce();
    bit ok;
    int p0;
    logic [3:0] exp_col;
    wait_col_enter_1110(ok);
    checks++; if (!ok) $display("FAIL rst_align_timeout: got col %b expected %b", col, 4'b1110); else passed++;
    p0 = pulses;
    press_col = 4'b1110;
    press_row = 4'b1101;
    press_on  = 1'b1;
    drive_row();
    repeat (8) cyc();
    checks++; if (col !== 4'b1110) $display("FAIL rst_debounce_col: got %b expected %b", col, 4'b1110); else passed++;
    #2 reset_p = 1'b1;
    #1;
    checks++; if (col !== 4'b1110) $display("FAIL rst_async_col: got %b expected %b", col, 4'b1110); else passed++;
    checks++; if (key_value !== 4'd0) $display("FAIL rst_async_key_value: got %b expected %b", key_value, 4'd0); else passed++;
    checks++; if (key_valid !== 1'b0) $display("FAIL rst_async_key_valid: got %b expected 0", key_valid); else passed++;
    checks++; if (key_held !== 1'b0) $display("FAIL rst_async_key_held: got %b expected 0", key_held); else passed++;
    press_on = 1'b0;
    repeat (3) cyc();
    reset_p = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_col = (i < 4) ? 4'b1110 : ((i < 8) ? 4'b1101 : 4'b1011);
      checks++; if (col !== exp_col) $display("FAIL rst_restart_col[%0d]: got %b expected %b", i, col, exp_col); else passed++;
      cyc();
    end
    checks++; if (pulses - p0 !== 0) $display("FAIL rst_pulses: got %0d expected 0", pulses - p0); else passed++;
    checks++; if (key_value !== 4'd0) $display("FAIL rst_key_value_after: got %b expected %b", key_value, 4'd0); else passed++;
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    pulses    = 0;
    consec    = 0;
    prev_kv   = 1'b0;
    press_on  = 1'b0;
    press_all = 1'b0;
    press_col = 4'b1111;
    press_row = 4'b1111;
    row       = 4'b1111;
    test_reset();
    test_idle_scan();
    test_press();
    test_bounce();
    test_release_glitch();
    test_multi_key();
    test_reset_mid_debounce();
    checks++; if (consec !== 0) $display("FAIL valid_consecutive: got %0d expected 0", consec); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
